// File: rtl/alu_decoder_if.sv
// Decode bus between the main decoder and the ALU control decoder.
// Carries the operation inputs together with the combinational and registered decode results.
interface alu_decoder_if;
    logic [1:0] alu_op_in;
    logic [2:0] funct3_in;
    logic [1:0] funct7_in;
    logic [2:0] alu_control_out;
    logic       illegal_out;
    logic [2:0] alu_control_q;
    logic       illegal_q;

    modport master (
        output alu_op_in,
        output funct3_in,
        output funct7_in,
        input  alu_control_out,
        input  illegal_out,
        input  alu_control_q,
        input  illegal_q
    );

    modport slave (
        input  alu_op_in,
        input  funct3_in,
        input  funct7_in,
        output alu_control_out,
        output illegal_out,
        output alu_control_q,
        output illegal_q
    );
endinterface

// File: rtl/alu_decoder.sv
// ALU control decoder: combinational decode of alu_op/funct3/funct7 into an ALU control code,
// plus a one-cycle registered copy with synchronous active-low reset.
module alu_decoder (
    input  logic              clk,
    input  logic              rst_n,
    alu_decoder_if.slave      bus
);

    localparam logic [2:0] CtlAdd = 3'b000;
    localparam logic [2:0] CtlSub = 3'b001;
    localparam logic [2:0] CtlAnd = 3'b010;
    localparam logic [2:0] CtlOr  = 3'b011;
    localparam logic [2:0] CtlSlt = 3'b101;

    logic       op_add;
    logic       op_sub;
    logic       op_rtype;
    logic       op_rsvd;
    logic       f3_addsub;
    logic       f3_slt;
    logic       f3_or;
    logic       f3_and;
    logic       f3_unsup;
    logic       sel_sub;
    logic       sel_slt;
    logic       sel_or;
    logic       sel_and;
    logic [2:0] alu_control_d;
    logic       illegal_d;
    logic [2:0] alu_control_q;
    logic       illegal_q;

    // Sum-of-products form so an X on a live input propagates instead of falling into a default.
    always_comb begin
        op_add    = (bus.alu_op_in == 2'b00);
        op_sub    = (bus.alu_op_in == 2'b01);
        op_rtype  = (bus.alu_op_in == 2'b10);
        op_rsvd   = (bus.alu_op_in == 2'b11);

        f3_addsub = (bus.funct3_in == 3'b000);
        f3_slt    = (bus.funct3_in == 3'b010);
        f3_or     = (bus.funct3_in == 3'b110);
        f3_and    = (bus.funct3_in == 3'b111);
        f3_unsup  = (bus.funct3_in == 3'b001) | (bus.funct3_in == 3'b011) |
                    (bus.funct3_in == 3'b100) | (bus.funct3_in == 3'b101);

        sel_sub   = op_sub | (op_rtype & f3_addsub & (bus.funct7_in == 2'b11));
        sel_slt   = op_rtype & f3_slt;
        sel_or    = op_rtype & f3_or;
        sel_and   = op_rtype & f3_and;

        alu_control_d = ({3{sel_sub}} & CtlSub) |
                        ({3{sel_slt}} & CtlSlt) |
                        ({3{sel_or}}  & CtlOr)  |
                        ({3{sel_and}} & CtlAnd) |
                        ({3{op_add}}  & CtlAdd);

        illegal_d = op_rsvd | (op_rtype & f3_unsup);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_control_q <= CtlAdd;
            illegal_q     <= 1'b0;
        end else begin
            alu_control_q <= alu_control_d;
            illegal_q     <= illegal_d;
        end
    end

    assign bus.alu_control_out = alu_control_d;
    assign bus.illegal_out     = illegal_d;
    assign bus.alu_control_q   = alu_control_q;
    assign bus.illegal_q       = illegal_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Directed bench for alu_decoder: a rule-level decode model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_alu_decoder;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic cmp_on;
    logic exp_valid;
    logic [3:0] exp_q;

    alu_decoder_if u_if ();

    alu_decoder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {illegal, control} straight from the decode rules.
    function automatic logic [3:0] model(input logic [1:0] op, input logic [2:0] f3,
                                         input logic [1:0] f7);
        logic [3:0] r;
        case (op)
            2'd0: r = 4'b0_000;
            2'd1: r = 4'b0_001;
            2'd2: begin
                case (f3)
                    3'b000:  r = (f7 == 2'b11) ? 4'b0_001 : 4'b0_000;
                    3'b010:  r = 4'b0_101;
                    3'b110:  r = 4'b0_011;
                    3'b111:  r = 4'b0_010;
                    default: r = 4'b1_000;
                endcase
            end
            default: r = 4'b1_000;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got illegal/ctl %b/%b, expected %b/%b at %0t",
                     name, got[3], got[2:0], exp[3], exp[2:0], $time);
        end
    endtask

    function automatic logic [3:0] comb_out();
        return {u_if.illegal_out, u_if.alu_control_out};
    endfunction

    function automatic logic [3:0] reg_out();
        return {u_if.illegal_q, u_if.alu_control_q};
    endfunction

    // Expected register contents, captured from the inputs present at each rising edge.
    always @(posedge clk) begin
        exp_q     = rst_n ? model(u_if.alu_op_in, u_if.funct3_in, u_if.funct7_in) : 4'b0_000;
        exp_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_comb", comb_out(), model(u_if.alu_op_in, u_if.funct3_in, u_if.funct7_in));
            if (exp_valid) chk("model_reg", reg_out(), exp_q);
        end
    end

    task automatic set_in(input logic [1:0] op, input logic [2:0] f3, input logic [1:0] f7);
        u_if.alu_op_in = op;
        u_if.funct3_in = f3;
        u_if.funct7_in = f7;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cmp_on    = 1'b0;
        exp_valid = 1'b0;
        exp_q     = 4'b0;
        rst_n     = 1'b0;
        set_in(2'b00, 3'b000, 2'b00);
        step();
        cmp_on = 1'b1;
        chk("reset_state", reg_out(), 4'b0_000);
        rst_n = 1'b1;

        // op 00 / 01 ignore funct fields
        set_in(2'b00, 3'b101, 2'b11);
        chk("op00_add", comb_out(), 4'b0_000);
        step();
        set_in(2'b01, 3'b111, 2'b01);
        chk("op01_sub", comb_out(), 4'b0_001);
        step();

        begin
            logic [2:0] exp_ctl [4];
            exp_ctl = '{3'b000, 3'b000, 3'b000, 3'b001};
            for (int i = 0; i < 4; i++) begin
                set_in(2'b10, 3'b000, 2'(i));
                chk($sformatf("rtype_f7_%0d", i), comb_out(), {1'b0, exp_ctl[i]});
                step();
            end
        end

        begin
            logic [2:0] f3s [3];
            logic [2:0] ctl [3];
            f3s = '{3'b010, 3'b110, 3'b111};
            ctl = '{3'b101, 3'b011, 3'b010};
            for (int i = 0; i < 3; i++) begin
                set_in(2'b10, f3s[i], 2'b11);
                chk($sformatf("rtype_f3_%b", f3s[i]), comb_out(), {1'b0, ctl[i]});
                step();
            end
        end

        begin
            logic [2:0] bad [4];
            bad = '{3'b001, 3'b011, 3'b100, 3'b101};
            for (int i = 0; i < 4; i++) begin
                set_in(2'b10, bad[i], 2'b00);
                chk($sformatf("illegal_f3_%b", bad[i]), comb_out(), 4'b1_000);
                step();
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_in(2'b11, 3'(i * 2 + 1), 2'(i));
            chk($sformatf("rsvd_op_%0d", i), comb_out(), 4'b1_000);
            step();
        end

        // Synchronous reset with a SUB decode on the inputs
        set_in(2'b10, 3'b000, 2'b11);
        step();
        chk("pre_reset_q", reg_out(), 4'b0_001);
        rst_n = 1'b0;
        #1;
        chk("reset_not_async", reg_out(), 4'b0_001);
        step();
        chk("reset_q_clear", reg_out(), 4'b0_000);
        chk("reset_comb_live", comb_out(), 4'b0_001);
        rst_n = 1'b1;
        step();
        chk("post_reset_q", reg_out(), 4'b0_001);

        // Back-to-back input changes, one edge of latency each
        set_in(2'b01, 3'b000, 2'b00);
        step();
        chk("pipe_sub", reg_out(), 4'b0_001);
        set_in(2'b10, 3'b111, 2'b00);
        step();
        chk("pipe_and", reg_out(), 4'b0_010);
        set_in(2'b11, 3'b000, 2'b00);
        step();
        chk("pipe_illegal", reg_out(), 4'b1_000);

        step();
        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 clk  input  1  single clock; all registered outputs update on its rising edge only.
REQ-002 rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-003 alu_op_in  input  2  ALU operation class from the main decoder: 00 load/store/add, 01 branch/subtract, 10 R/I-type ALU, 11 reserved.
REQ-004 funct3_in  input  3  instruction funct3 field.
REQ-005 funct7_in  input  2  bit1 = opcode[5], bit0 = funct7[5]; 11 marks R-type SUB.
REQ-006 alu_control_out  output  3  combinational ALU control code.
REQ-007 illegal_out  output  1  combinational flag; 1 = unsupported alu_op_in/funct3_in combination.
REQ-008 alu_control_q  output  3  alu_control_out registered, one clk of latency.
REQ-009 illegal_q  output  1  illegal_out registered, one clk of latency.

Function
REQ-010 ALU control encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; codes 100, 110 and 111 SHALL never be driven.
REQ-011 alu_control_out and illegal_out SHALL be pure combinational functions of alu_op_in, funct3_in and funct7_in, with no dependence on clk or rst_n.
REQ-012 alu_op_in=00 SHALL give ADD (000), illegal_out=0, with funct3_in and funct7_in ignored.
REQ-013 alu_op_in=01 SHALL give SUB (001), illegal_out=0, with funct3_in and funct7_in ignored.
REQ-014 alu_op_in=10 with funct3_in=000 SHALL give SUB (001) when funct7_in=11; it SHALL give ADD (000) for funct7_in=00, 01 or 10.
REQ-015 alu_op_in=10 with funct3_in=010 SHALL give SLT (101), with funct7_in ignored.
REQ-016 alu_op_in=10 with funct3_in=110 SHALL give OR (011), with funct7_in ignored.
REQ-017 alu_op_in=10 with funct3_in=111 SHALL give AND (010), with funct7_in ignored.
REQ-018 alu_op_in=10 with funct3_in in {001,011,100,101} SHALL give ADD (000) and illegal_out=1.
REQ-019 alu_op_in=11 SHALL give ADD (000) and illegal_out=1 for all funct3_in and funct7_in.
REQ-020 Any X/Z on an input that the active row does not ignore SHALL NOT be masked; outputs MAY go X in that case.
REQ-021 On each rising clk edge with rst_n=1, alu_control_q SHALL load alu_control_out and illegal_q SHALL load illegal_out.
REQ-022 The registers SHALL have no enable and no hold condition; a new input value SHALL appear on the _q outputs exactly one edge later.

Reset
REQ-023 On a rising clk edge with rst_n=0, alu_control_q SHALL become 000 and illegal_q SHALL become 0.
REQ-024 rst_n SHALL have no asynchronous effect; asserting it between edges SHALL leave the _q outputs unchanged until the next edge.
REQ-025 During reset, alu_control_out and illegal_out SHALL continue to follow the inputs combinationally.
REQ-026 On the first edge after rst_n returns to 1, the _q outputs SHALL capture the current decode.

Verification
REQ-027 The bench SHALL cover these six directed scenarios:
- alu_op_in=00, then 01, funct3/funct7 arbitrary -> alu_control_out 000, then 001; illegal_out 0.
- alu_op_in=10, funct3_in=000, funct7_in swept 00/01/10/11 -> 000, 000, 000, 001.
- alu_op_in=10, funct3_in=010/110/111 -> 101/011/010; illegal_out 0.
- alu_op_in=10, funct3_in=001/011/100/101, and alu_op_in=11 -> alu_control_out 000, illegal_out 1.
- rst_n=0 over one edge with inputs decoding SUB -> alu_control_q 000, illegal_q 0, while alu_control_out stays 001; after rst_n=1, next edge -> alu_control_q 001.
- Inputs changed every cycle (01, then 10/111, then 11) -> _q outputs show 001, 010/0, 000/1, each one edge after the input change.
